// File: rtl/dds_core.sv
// rtl/dds_core.sv - parametrised DDS core with quarter-wave sine table and linear sweep
//
// Purpose: phase accumulator with double-buffered tuning word and phase offset,
// optional linear frequency sweep, and a quarter-wave sine lookup with symmetry
// folding. The sine output is signed and pipelined, and carries a valid flag.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   en           accumulator advance enable
//   freq_word    pending frequency tuning word
//   phase_off    pending phase offset
//   load         strobe: copy freq_word/phase_off into the active registers
//   sweep_en     linear sweep enable
//   sweep_step   per-cycle increment of the active frequency word
//   sweep_limit  unsigned upper sweep bound
//   sine_out     signed sample, four edges after the accumulator value
//   valid        en delayed by four edges
//   phase_acc    current accumulator value
//   sweep_done   sticky: sweep reached sweep_limit
module dds_core #(
  parameter int PHASE_W  = 32,
  parameter int ADDR_W   = 10,
  parameter int OUT_W    = 16,
  parameter     LUT_FILE = "sin_quarter.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic [PHASE_W-1:0]      phase_off,
  input  logic                    load,
  input  logic                    sweep_en,
  input  logic [PHASE_W-1:0]      sweep_step,
  input  logic [PHASE_W-1:0]      sweep_limit,
  output logic signed [OUT_W-1:0] sine_out,
  output logic                    valid,
  output logic [PHASE_W-1:0]      phase_acc,
  output logic                    sweep_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int P_W   = ADDR_W + 2;

  // Table contents are generated at elaboration from the same formula used to
  // produce LUT_FILE, so the core does not depend on a file being present.
  // sin() is a Taylor series; over (0, pi/2) twelve terms are far below one LSB.
  function automatic logic [OUT_W-1:0] rom_entry(input int i);
    real x;
    real term;
    real s;
    real amp;
    x    = 6.283185307179586 * (real'(i) + 0.5) / real'(DEPTH * 4);
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    amp = real'((1 << (OUT_W - 1)) - 1);
    return OUT_W'($rtoi(amp * s + 0.5));
  endfunction

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [OUT_W-1:0] ENTRY = rom_entry(gi);
    assign rom[gi] = ENTRY;
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] freq_q, freq_d;
  logic [PHASE_W-1:0] off_q, off_d;
  logic               done_q, done_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               neg2_q, neg2_d;
  logic               neg3_q, neg3_d;
  logic [OUT_W-1:0]   rom_q, rom_d;
  logic [OUT_W-1:0]   sine_q, sine_d;
  logic [3:0]         vld_q, vld_d;
  logic [PHASE_W:0]   sweep_sum;

  always_comb begin
    acc_d  = acc_q;
    freq_d = freq_q;
    off_d  = off_q;
    done_d = done_q;

    // One extra carry bit so a step that would overflow still counts as
    // having reached the limit.
    sweep_sum = {1'b0, freq_q} + {1'b0, sweep_step};

    // The accumulator always uses the freq_act value from before this edge.
    if (en) begin
      acc_d = acc_q + freq_q;
    end

    if (load) begin
      freq_d = freq_word;
      off_d  = phase_off;
      done_d = 1'b0;
    end else if (sweep_en && en) begin
      if (done_q || (sweep_sum >= {1'b0, sweep_limit})) begin
        freq_d = sweep_limit;
        done_d = 1'b1;
      end else begin
        freq_d = sweep_sum[PHASE_W-1:0];
      end
    end

    // S1: top ADDR_W+2 bits of the offset phase.
    p_d = P_W'((acc_q + off_q) >> (PHASE_W - P_W));

    // S2: odd quadrants mirror the index, the upper half-wave negates.
    idx_d  = p_q[ADDR_W] ? ~p_q[ADDR_W-1:0] : p_q[ADDR_W-1:0];
    neg2_d = p_q[P_W-1];

    // S3: registered table read.
    rom_d  = rom[idx_q];
    neg3_d = neg2_q;

    // S4: entries are strictly positive, so the negation cannot overflow.
    sine_d = neg3_q ? (~rom_q + 1'b1) : rom_q;

    vld_d = {vld_q[2:0], en};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      freq_q <= '0;
      off_q  <= '0;
      done_q <= 1'b0;
      p_q    <= '0;
      idx_q  <= '0;
      neg2_q <= 1'b0;
      neg3_q <= 1'b0;
      rom_q  <= '0;
      sine_q <= '0;
      vld_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      freq_q <= freq_d;
      off_q  <= off_d;
      done_q <= done_d;
      p_q    <= p_d;
      idx_q  <= idx_d;
      neg2_q <= neg2_d;
      neg3_q <= neg3_d;
      rom_q  <= rom_d;
      sine_q <= sine_d;
      vld_q  <= vld_d;
    end
  end

  assign sine_out   = sine_q;
  assign valid      = vld_q[3];
  assign phase_acc  = acc_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_dds_core.sv
// tb/tb_dds_core.sv - scoreboard testbench for dds_core
module tb_dds_core;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               load;
  logic               sweep_en;
  logic [31:0]        freq_word;
  logic [31:0]        phase_off;
  logic [31:0]        sweep_step;
  logic [31:0]        sweep_limit;
  logic signed [15:0] sine_out;
  logic               valid;
  logic [31:0]        phase_acc;
  logic               sweep_done;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Reference state: active registers and accumulator as plain values.
  logic [31:0] m_acc;
  logic [31:0] m_freq;
  logic [31:0] m_off;
  logic        m_done;

  int   exp_q[$];
  int   seen_q[$];
  logic en_hist[$];
  int   mon_e;

  dds_core dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .freq_word  (freq_word),
    .phase_off  (phase_off),
    .load       (load),
    .sweep_en   (sweep_en),
    .sweep_step (sweep_step),
    .sweep_limit(sweep_limit),
    .sine_out   (sine_out),
    .valid      (valid),
    .phase_acc  (phase_acc),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  // Full-wave sine at 12-bit phase resolution, half-sample centred, rounded
  // symmetrically about zero.
  function automatic int ref_sample(input logic [31:0] ph);
    real         v;
    logic [11:0] idx;
    idx = ph[31:20];
    v   = 32767.0 * $sin(2.0 * 3.141592653589793 * (real'(idx) + 0.5) / 4096.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, predict, then compare after the edge.
  task automatic cyc(input logic e, input logic l, input logic [31:0] fw,
                     input logic [31:0] po, input logic se,
                     input logic [31:0] ss, input logic [31:0] sl);
    logic [32:0] s;
    logic [31:0] f_old;
    en = e; load = l; freq_word = fw; phase_off = po;
    sweep_en = se; sweep_step = ss; sweep_limit = sl;
    if (e) exp_q.push_back(ref_sample(m_acc + m_off));
    en_hist.push_back(e);
    @(posedge clk);
    f_old = m_freq;
    if (l) begin
      m_freq = fw; m_off = po; m_done = 1'b0;
    end else if (se && e) begin
      s = {1'b0, m_freq} + {1'b0, ss};
      if (m_done || s >= {1'b0, sl}) begin
        m_freq = sl; m_done = 1'b1;
      end else begin
        m_freq = s[31:0];
      end
    end
    if (e) m_acc = m_acc + f_old;
    #1;
    chk("phase_acc", phase_acc, m_acc);
    chk("sweep_done", sweep_done, m_done);
    if (en_hist.size() > 4) void'(en_hist.pop_front());
    chk("valid", valid, (en_hist.size() == 4) ? en_hist[0] : 1'b0);
  endtask

  // Asserts reset mid-cycle and checks outputs clear before the next edge.
  task automatic do_reset();
    en = 1'b0; load = 1'b0; sweep_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_sine", sine_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_acc", phase_acc, 0);
    chk("rst_done", sweep_done, 0);
    m_acc = '0; m_freq = '0; m_off = '0; m_done = 1'b0;
    exp_q.delete();
    en_hist.delete();
    armed = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_tone(input logic [31:0] po, input int ex[4]);
    do_reset();
    cyc(1'b0, 1'b1, 32'h4000_0000, po, 1'b0, 0, 0);
    seen_q.delete();
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("tone_count", seen_q.size() >= 8, 1);
    for (int i = 0; i < 8 && i < seen_q.size(); i++) chk("tone_seq", seen_q[i], ex[i % 4]);
  endtask

  always @(negedge clk) begin
    if (armed && reset && valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got sample %0d expected no sample", sine_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sine_out", sine_out, mon_e);
        seen_q.push_back(int'(sine_out));
      end
    end
  end

  initial begin
    longint tone_acc[4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 0};
    int     tone_exp[4] = '{25, 32767, -25, -32767};
    int     off_exp[4]  = '{32767, -25, -32767, 25};
    longint sw_acc[5];
    logic [31:0] held;

    reset = 1'b1; en = 1'b0; load = 1'b0; sweep_en = 1'b0;
    freq_word = '0; phase_off = '0; sweep_step = '0; sweep_limit = '0;
    m_acc = '0; m_freq = '0; m_off = '0; m_done = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Quarter-cycle tone, including the accumulator steps.
    do_reset();
    cyc(1'b0, 1'b1, 32'h4000_0000, 0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
      chk("tone_acc", phase_acc, tone_acc[i]);
    end
    run_tone(32'h0, tone_exp);
    run_tone(32'h4000_0000, off_exp);

    // Latency and enable: en 1,0,1; held phase repeats the same sample.
    do_reset();
    cyc(1'b0, 1'b1, 32'h0123_4567, 32'h0800_0000, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    held = m_acc;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
      chk("hold_acc", phase_acc, held);
      if (i >= 4) chk("hold_sine", sine_out, ref_sample(held + 32'h0800_0000));
    end
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);

    // Sweep 0 -> 100, 200, 250, 250 seen as accumulator increments.
    do_reset();
    cyc(1'b0, 1'b1, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b1, 100, 250);
      sw_acc[i] = phase_acc;
      if (i == 1) chk("sweep_done_early", sweep_done, 0);
      if (i == 2) chk("sweep_done_third", sweep_done, 1);
    end
    chk("sweep_f1", sw_acc[1] - sw_acc[0], 100);
    chk("sweep_f2", sw_acc[2] - sw_acc[1], 200);
    chk("sweep_f3", sw_acc[3] - sw_acc[2], 250);
    chk("sweep_f4", sw_acc[4] - sw_acc[3], 250);
    cyc(1'b0, 1'b1, 32'h10, 0, 1'b1, 100, 250);
    chk("sweep_load_clear", sweep_done, 0);

    // Wrap with all-ones tuning word, then reset mid-stream.
    do_reset();
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("wrap_1", phase_acc, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("wrap_2", phase_acc, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("post_reset_acc", phase_acc, 0);

    // Randomised traffic, including occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom(), $urandom(), $urandom_range(0, 1) == 1,
            32'($urandom_range(1, 1 << 24)), $urandom());
      end
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_core.md
# dds_core

Parametrised direct digital synthesis core: phase accumulator, phase offset, quarter-wave sine lookup and optional linear frequency sweep. It generalises the single-channel DDS in width and table depth. It adds:
- double-buffered tuning words;
- symmetry folding, so only a quarter-wave table is stored;
- a signed, pipelined output with a valid flag.

It sits between the register/control logic and the DAC interface.

## Interface
- PHASE_W, 32, accumulator, tuning word and offset width
- ADDR_W, 10, quarter-wave table address width; full-wave resolution is ADDR_W+2 bits
- OUT_W, 16, signed sine sample width
- LUT_FILE, "sin_quarter.hex", quarter-wave table init file
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  accumulator advance enable
- freq_word  in  PHASE_W  pending frequency tuning word
- phase_off  in  PHASE_W  pending phase offset
- load  in  1  one-cycle strobe: copy freq_word and phase_off into the active registers
- sweep_en  in  1  linear sweep enable
- sweep_step  in  PHASE_W  per-cycle increment of the active frequency word
- sweep_limit  in  PHASE_W  upper sweep bound (unsigned)
- sine_out  out  OUT_W  signed two's-complement sample
- valid  out  1  sine_out corresponds to an enabled accumulator cycle
- phase_acc  out  PHASE_W  current accumulator value
- sweep_done  out  1  sticky flag: sweep reached sweep_limit

## Operation
- Active registers are freq_act and off_act. On load, both take the input values at that edge, and sweep_done clears.
- Accumulator:
  - en=1: acc <= acc + freq_act, modulo 2^PHASE_W; wrap-around is silent.
  - en=0: acc holds.
- Sweep, evaluated only when sweep_en=1, en=1 and load=0:
  - If freq_act + sweep_step >= sweep_limit (computed with one carry bit, no wrap), then freq_act <= sweep_limit and sweep_done <= 1.
  - Otherwise freq_act <= freq_act + sweep_step.
  - Once sweep_done=1, freq_act stays at sweep_limit.
  - load in the same cycle has priority over the sweep update.
- Phase: p = (acc + off_act), top ADDR_W+2 bits. q = p[ADDR_W+1:ADDR_W] is the quadrant; a = p[ADDR_W-1:0] is the index.
- Folding:
  - table index = q[0] ? ~a : a
  - sample = q[1] ? -T[index] : T[index]
- Table: T[i] = round((2^(OUT_W-1)-1) * sin(2π(i+0.5)/2^(ADDR_W+2))), for i = 0 .. 2^ADDR_W-1.
  - All entries are positive. The half-sample offset makes the mirror and the negation exact.
  - Negation never produces -2^(OUT_W-1).
- Registered-ROM inference; no combinational read path to the output.

## Timing
- Pipeline:
  - S1 registers p.
  - S2 registers the folded index and the negate flag.
  - S3 is the ROM read.
  - S4 applies the negation and registers sine_out.
- Latency: the acc value present after edge k appears on sine_out after edge k+4.
- valid is en delayed by 4 edges through a shift register. The pipeline always advances; with en=0 it repeats the held phase and valid=0.
- load at edge k: freq_act is used by the accumulator from edge k+1. off_act affects p from edge k+1.
- Reset asserted, at any time and including mid-sweep:
  - acc, freq_act, off_act, all pipeline stages, sine_out, valid and sweep_done go to 0 immediately.
  - The first enabled edge after deassertion uses freq_act=0 until a load arrives.

## Test plan
- Quarter-cycle tone (defaults):
  - Stimulus: reset, load freq_word=2^30 and phase_off=0, then hold en=1.
  - Required: once valid rises, sine_out repeats 25, 32767, -25, -32767.
  - Required: phase_acc steps 2^30, 2^31, 3·2^30, 0.
- Phase offset: same as the quarter-cycle tone but phase_off=2^30 → the sequence is rotated by one sample (32767, -25, -32767, 25).
- Latency and enable:
  - Stimulus: toggle en as 1,0,1.
  - Required: valid follows 4 edges later.
  - Required: while en=0, phase_acc is constant and the repeated output sample is unchanged.
- Sweep:
  - Stimulus: load freq_word=0, then sweep_en=1, sweep_step=100, sweep_limit=250, en=1.
  - Required: freq_act goes 100, 200, 250, 250.
  - Required: sweep_done rises on the third edge, and a later load clears it.
- Wrap and reset:
  - Stimulus: freq_word=2^32-1 → acc decrements by 1 per edge, modulo 2^32.
  - Stimulus: assert reset mid-stream → all outputs read 0 before the next clock edge.
